alu_datapath: RTL and testbench

//  8-bit register datapath (A, Q, M, Q_1, COUNT) driven by the one-hot-ish control

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_adder.sv | 19 +
 rtl/alu_datapath.sv | 115 +++++++++++
 tb/tb_alu_datapath.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation encodings and control-word bit indices.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  // Bit positions of each control in the control word emitted by ALU_CU
  localparam int CTL_C0      = 0;
  localparam int CTL_C0_PRIM = 1;
  localparam int CTL_C1      = 2;
  localparam int CTL_C2      = 3;
  localparam int CTL_C3      = 4;
  localparam int CTL_C4      = 5;
  localparam int CTL_CR      = 6;
  localparam int CTL_CL      = 7;
  localparam int CTL_C5      = 8;
  localparam int CTL_C7_5    = 9;
  localparam int CTL_C6      = 10;
  localparam int CTL_C7      = 11;
  localparam int CTL_C8      = 12;
  localparam int CTL_NUM     = 13;

endpackage

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder/subtractor with two's-complement signed-overflow flag.
module alu_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
  // Overflow judged against the inverted operand so subtraction shares the add rule
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_datapath.sv
// A/Q/M/Q_1/COUNT register datapath for add, sub, Booth multiply and divide; controls act on the sampling edge.
// Define ALU_OVF_EN to keep a signed-overflow flag for c2/c3; otherwise OVF is tied low.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] INBUS,
  input  logic             c0,
  input  logic             c0_prim,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             c4,
  input  logic             cR,
  input  logic             cL,
  input  logic             c5,
  input  logic             c7_5,
  input  logic             c6,
  input  logic             c7,
  input  logic             c8,
  output logic             CNT7,
  output logic             Q0,
  output logic             Q_1,
  output logic             A7,
  output logic [WIDTH-1:0] OUTBUS,
  output logic             DONE,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             q1_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  // c2 outranks c3, so subtract only when c3 is alone; c7_5 always adds
  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (a_q),
    .b   (m_q),
    .sub (c3 & ~c2),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      OUTBUS <= '0;
      DONE   <= 1'b0;
    end else begin
      if (c0)           a_q <= '0;
      else if (c0_prim) a_q <= INBUS;
      else if (c2 | c3) a_q <= sum;
      else if (c7_5) begin
        if (a_q[WIDTH-1]) a_q <= sum;
      end
      else if (cR)      a_q <= {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      else if (cL)      a_q <= {a_q[WIDTH-2:0], q_q[WIDTH-1]};

      // Shifts read the pre-edge A, so a same-cycle A write does not leak into Q
      if (c1)      q_q <= INBUS;
      else if (cR) q_q <= {a_q[0], q_q[WIDTH-1:1]};
      else if (cL) q_q <= {q_q[WIDTH-2:0], c5};
      else if (c5) q_q[0] <= 1'b1;

      if (c0) m_q <= INBUS;

      if (c0)      q1_q <= 1'b0;
      else if (cR) q1_q <= q_q[0];

      if (c0)      cnt_q <= '0;
      else if (c4) cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;

      if (c6)      OUTBUS <= a_q;
      else if (c7) OUTBUS <= q_q;

      if (c8)      DONE <= 1'b1;
      else if (c0) DONE <= 1'b0;
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_q;

  always_ff @(posedge CLK) begin
    if (RST)          ovf_q <= 1'b0;
    else if (c0)      ovf_q <= 1'b0;
    else if (c2 | c3) ovf_q <= sum_ovf;
  end

  assign OVF = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = sum_ovf;
  assign OVF        = 1'b0;
`endif

  assign CNT7 = (cnt_q == CNT_MAX);
  assign Q0   = q_q[0];
  assign Q_1  = q1_q;
  assign A7   = a_q[WIDTH-1];

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath: add/sub, Booth multiply, shifts, priority, reset.
module tb_alu_datapath;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] INBUS;
  logic       c0, c0_prim, c1, c2, c3, c4, cR, cL, c5, c7_5, c6, c7, c8;
  logic       CNT7, Q0, Q_1, A7, DONE, OVF;
  logic [7:0] OUTBUS;

  int checks = 0;
  int errors = 0;

`ifdef ALU_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  // Booth schedule for M=-3, Q=5: 1 = subtract, 2 = add, 0 = shift only
  int booth_op [8] = '{1, 2, 1, 2, 0, 0, 0, 0};

  alu_datapath dut (
    .CLK     (CLK),
    .RST     (RST),
    .INBUS   (INBUS),
    .c0      (c0),
    .c0_prim (c0_prim),
    .c1      (c1),
    .c2      (c2),
    .c3      (c3),
    .c4      (c4),
    .cR      (cR),
    .cL      (cL),
    .c5      (c5),
    .c7_5    (c7_5),
    .c6      (c6),
    .c7      (c7),
    .c8      (c8),
    .CNT7    (CNT7),
    .Q0      (Q0),
    .Q_1     (Q_1),
    .A7      (A7),
    .OUTBUS  (OUTBUS),
    .DONE    (DONE),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic clr();
    RST = 1'b0; c0 = 1'b0; c0_prim = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0; c4 = 1'b0;
    cR = 1'b0; cL = 1'b0; c5 = 1'b0; c7_5 = 1'b0; c6 = 1'b0; c7 = 1'b0; c8 = 1'b0;
  endtask

  // One clock: inputs already applied, outputs settled 1ns after the edge, controls dropped
  task automatic tick();
    @(posedge CLK);
    #1;
    clr();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic rd_a(input string tag, input logic [7:0] exp);
    c6 = 1'b1; tick(); chk(tag, OUTBUS, exp);
  endtask

  task automatic rd_q(input string tag, input logic [7:0] exp);
    c7 = 1'b1; tick(); chk(tag, OUTBUS, exp);
  endtask

  initial begin
    clr();
    INBUS = 8'h00;
    RST = 1'b1; tick();
    chk("rst_outbus", OUTBUS, 8'h00);
    chk("rst_done", {7'd0, DONE}, 8'h00);
    chk("rst_cnt7", {7'd0, CNT7}, 8'h00);
    chk("rst_q0", {7'd0, Q0}, 8'h00);
    chk("rst_q_1", {7'd0, Q_1}, 8'h00);
    chk("rst_a7", {7'd0, A7}, 8'h00);
    chk("rst_ovf", {7'd0, OVF}, 8'h00);

    // add 5 + 3
    INBUS = 8'h03; c0 = 1'b1; tick();
    INBUS = 8'h05; c0_prim = 1'b1; tick();
    c2 = 1'b1; tick();
    rd_a("add_out", 8'h08);
    chk("add_ovf", {7'd0, OVF}, 8'h00);

    // sub 3 - 5, then 0x7F - 0x80 overflows
    INBUS = 8'h05; c0 = 1'b1; tick();
    INBUS = 8'h03; c0_prim = 1'b1; tick();
    c3 = 1'b1; tick();
    chk("sub_a7", {7'd0, A7}, 8'h01);
    rd_a("sub_out", 8'hFE);
    chk("sub_ovf0", {7'd0, OVF}, 8'h00);
    INBUS = 8'h80; c0 = 1'b1; tick();
    INBUS = 8'h7F; c0_prim = 1'b1; tick();
    c3 = 1'b1; tick();
    chk("sub_ovf1", {7'd0, OVF}, {7'd0, OVF_EXP});
    rd_a("sub_ovf_out", 8'hFF);
    c0 = 1'b1; tick();
    chk("ovf_clr_c0", {7'd0, OVF}, 8'h00);

    // Booth multiply -3 * 5 = 0xFFF1
    INBUS = 8'hFD; c0 = 1'b1; tick();
    INBUS = 8'h05; c1 = 1'b1; tick();
    chk("mul_q0_init", {7'd0, Q0}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      if (booth_op[i] != 0) begin
        c3 = (booth_op[i] == 1);
        c2 = (booth_op[i] == 2);
        tick();
      end
      cR = 1'b1; c4 = 1'b1; tick();
      if (i == 0) chk("mul_q_1_step1", {7'd0, Q_1}, 8'h01);
      if (i == 5) chk("mul_cnt7_step6", {7'd0, CNT7}, 8'h00);
      if (i == 6) chk("mul_cnt7_step7", {7'd0, CNT7}, 8'h01);
    end
    chk("mul_cnt7_step8", {7'd0, CNT7}, 8'h00);
    rd_a("mul_a", 8'hFF);
    rd_q("mul_q", 8'hF1);
    chk("mul_done0", {7'd0, DONE}, 8'h00);
    c8 = 1'b1; tick();
    chk("mul_done1", {7'd0, DONE}, 8'h01);

    // shifts, c5, c7_5
    INBUS = 8'h02; c0 = 1'b1; tick();
    chk("c0_clr_done", {7'd0, DONE}, 8'h00);
    INBUS = 8'h80; c0_prim = 1'b1; tick();
    INBUS = 8'h01; c1 = 1'b1; tick();
    cR = 1'b1; tick();
    chk("shr_q_1", {7'd0, Q_1}, 8'h01);
    chk("shr_q0", {7'd0, Q0}, 8'h00);
    rd_a("shr_a", 8'hC0);
    rd_q("shr_q", 8'h00);
    cL = 1'b1; tick();
    rd_a("shl_a", 8'h80);
    rd_q("shl_q", 8'h00);
    cL = 1'b1; c5 = 1'b1; tick();
    rd_a("shl_c5_a", 8'h00);
    rd_q("shl_c5_q", 8'h01);
    INBUS = 8'h40; c1 = 1'b1; tick();
    c5 = 1'b1; tick();
    rd_q("c5_q", 8'h41);
    INBUS = 8'h90; c0_prim = 1'b1; tick();
    c7_5 = 1'b1; tick();
    rd_a("restore_neg", 8'h92);
    INBUS = 8'h10; c0_prim = 1'b1; tick();
    c7_5 = 1'b1; tick();
    rd_a("restore_pos", 8'h10);

    // priority
    INBUS = 8'h01; c0 = 1'b1; tick();
    INBUS = 8'h33; c0_prim = 1'b1; c2 = 1'b1; tick();
    INBUS = 8'h44; c1 = 1'b1; tick();
    c6 = 1'b1; c7 = 1'b1; tick();
    chk("c6_over_c7", OUTBUS, 8'h33);
    c2 = 1'b1; c3 = 1'b1; tick();
    rd_a("c2_over_c3", 8'h34);
    repeat (6) begin c4 = 1'b1; tick(); end
    c0 = 1'b1; c4 = 1'b1; c8 = 1'b1; tick();
    chk("c8_over_c0", {7'd0, DONE}, 8'h01);
    repeat (6) begin c4 = 1'b1; tick(); end
    chk("c0_over_c4_a", {7'd0, CNT7}, 8'h00);
    c4 = 1'b1; tick();
    chk("c0_over_c4_b", {7'd0, CNT7}, 8'h01);

    // reset during multiply step 4
    INBUS = 8'hFD; c0 = 1'b1; tick();
    INBUS = 8'h05; c1 = 1'b1; tick();
    c8 = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      c3 = (booth_op[i] == 1);
      c2 = (booth_op[i] == 2);
      tick();
      cR = 1'b1; c4 = 1'b1; tick();
    end
    rd_q("mid_q", 8'h20);
    c2 = 1'b1; RST = 1'b1; tick();
    chk("midrst_outbus", OUTBUS, 8'h00);
    chk("midrst_done", {7'd0, DONE}, 8'h00);
    chk("midrst_cnt7", {7'd0, CNT7}, 8'h00);
    chk("midrst_a7", {7'd0, A7}, 8'h00);
    chk("midrst_q0", {7'd0, Q0}, 8'h00);
    chk("midrst_q_1", {7'd0, Q_1}, 8'h00);
    chk("midrst_ovf", {7'd0, OVF}, 8'h00);
    repeat (4) begin c4 = 1'b1; tick(); end
    chk("midrst_count", {7'd0, CNT7}, 8'h00);
    rd_a("midrst_a", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
